// File: rtl/ir_pkg.sv
// Shared types for the IR key controller: event kinds, event record and NEC frame layout.
package ir_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } ir_evt_kind_e;

  typedef struct packed {
    ir_evt_kind_e kind;
    logic [7:0]   code;
  } ir_evt_t;

  localparam int NEC_ADDR_LSB  = 0;
  localparam int NEC_NADDR_LSB = 8;
  localparam int NEC_CMD_LSB   = 16;
  localparam int NEC_NCMD_LSB  = 24;

  function automatic logic [7:0] nec_byte(input logic [31:0] frame, input int lsb);
    return frame[lsb +: 8];
  endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Synchronous event FIFO whose head is presented through registered outputs.
module ir_evt_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  ir_evt_t                  wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_count,
  output logic                     o_valid,
  output ir_evt_t                  o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ir_evt_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic            w_wr_en;
  logic            w_rd_en;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  assign full       = (r_cnt == CW'(DEPTH));
  assign empty      = (r_cnt == '0);
  assign free_count = CW'(DEPTH) - r_cnt;

  assign w_wr_en   = push && !full;
  assign w_rd_en   = pop && !empty;
  assign w_rd_nxt  = r_rd + AW'(w_rd_en);
  assign w_cnt_nxt = r_cnt + CW'(w_wr_en) - CW'(w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= wdata;
  end

  // The head register bypasses the array when the next head is the entry being written now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      o_valid <= 1'b0;
      o_head  <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_wr_en);
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      o_valid <= (w_cnt_nxt != '0);
      o_head  <= (w_wr_en && (w_rd_nxt == r_wr)) ? wdata : r_mem[w_rd_nxt];
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// Turns NEC decoder frames into press/repeat/release key events with FIFO back-pressure.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR      = 8'h00,
  parameter bit          ADDR_ANY      = 1'b0,
  parameter logic [15:0] RELEASE_TICKS = 16'd12000,
  parameter logic [3:0]  REPEAT_FRAMES = 4'd3,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_ready,
  input  logic [31:0] dec_command,
  output logic        dec_enable,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_code,
  output logic [1:0]  evt_kind,
  output logic        held,
  output logic [7:0]  err_count
);

  typedef enum logic {ST_IDLE, ST_HELD} state_e;

  state_e      r_state;
  logic        r_rdy_q, r_rdy_q2, r_cap_vld;
  logic [31:0] r_frame;
  logic [7:0]  r_key;
  logic [3:0]  r_rpt;
  logic [15:0] r_timer;
  logic        r_push, r_pend, r_held, r_dec_en;
  ir_evt_t     r_push_evt;
  logic [7:0]  r_err;

  logic        w_full, w_empty, w_valid, w_pop, w_drop;
  logic        w_frame_ok, w_frame_bad, w_cmd_ok, w_addr_ok;
  logic [7:0]  w_addr, w_naddr, w_cmd, w_ncmd;
  logic [$clog2(FIFO_DEPTH):0] w_free;
  ir_evt_t     w_head;

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Frame edge detection on the registered ready level; the command is sampled on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_q   <= 1'b0;
      r_rdy_q2  <= 1'b0;
      r_cap_vld <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_rdy_q   <= dec_ready;
      r_rdy_q2  <= r_rdy_q;
      r_cap_vld <= r_rdy_q && !r_rdy_q2;
      if (r_rdy_q && !r_rdy_q2) r_frame <= dec_command;
    end
  end

  assign w_addr      = nec_byte(r_frame, NEC_ADDR_LSB);
  assign w_naddr     = nec_byte(r_frame, NEC_NADDR_LSB);
  assign w_cmd       = nec_byte(r_frame, NEC_CMD_LSB);
  assign w_ncmd      = nec_byte(r_frame, NEC_NCMD_LSB);
  assign w_cmd_ok    = (w_cmd == ~w_ncmd);
  assign w_addr_ok   = ADDR_ANY || ((w_addr == ~w_naddr) && (w_addr == DEV_ADDR));
  assign w_frame_ok  = r_cap_vld && w_cmd_ok && w_addr_ok;
  assign w_frame_bad = r_cap_vld && !(w_cmd_ok && w_addr_ok);

  // A key change pushes release now and leaves the press pending for the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_held     <= 1'b0;
      r_key      <= '0;
      r_rpt      <= '0;
      r_timer    <= '0;
      r_push     <= 1'b0;
      r_push_evt <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_pend) begin
        r_push     <= 1'b1;
        r_push_evt <= '{kind: EVT_PRESS, code: r_key};
        r_pend     <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_frame_ok) begin
            r_push     <= 1'b1;
            r_push_evt <= '{kind: EVT_PRESS, code: w_cmd};
            r_key      <= w_cmd;
            r_rpt      <= '0;
            r_timer    <= '0;
            r_state    <= ST_HELD;
            r_held     <= 1'b1;
          end
        end
        ST_HELD: begin
          if (w_frame_ok) begin
            r_timer <= '0;
            if (w_cmd == r_key) begin
              if (r_rpt + 4'd1 == REPEAT_FRAMES) begin
                r_rpt      <= '0;
                r_push     <= 1'b1;
                r_push_evt <= '{kind: EVT_REPEAT, code: r_key};
              end else begin
                r_rpt <= r_rpt + 4'd1;
              end
            end else begin
              r_push     <= 1'b1;
              r_push_evt <= '{kind: EVT_RELEASE, code: r_key};
              r_pend     <= 1'b1;
              r_key      <= w_cmd;
              r_rpt      <= '0;
            end
          end else if (r_timer == RELEASE_TICKS - 16'd1) begin
            r_push     <= 1'b1;
            r_push_evt <= '{kind: EVT_RELEASE, code: r_key};
            r_timer    <= '0;
            r_state    <= ST_IDLE;
            r_held     <= 1'b0;
          end else if (r_timer != 16'hFFFF) begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop  = evt_valid && evt_ready && !w_empty;
  assign w_drop = r_push && w_full;

  ir_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (r_push),
    .wdata      (r_push_evt),
    .pop        (w_pop),
    .full       (w_full),
    .empty      (w_empty),
    .free_count (w_free),
    .o_valid    (w_valid),
    .o_head     (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_en <= 1'b1;
      r_err    <= '0;
    end else begin
      r_dec_en <= (w_free >= ($clog2(FIFO_DEPTH)+1)'(2));
      r_err    <= sat_add(r_err, {1'b0, w_frame_bad} + {1'b0, w_drop});
    end
  end

  assign dec_enable = r_dec_en;
  assign evt_valid  = w_valid;
  assign evt_code   = w_head.code;
  assign evt_kind   = w_head.kind;
  assign held       = r_held;
  assign err_count  = r_err;

endmodule
